// File: rtl/decoder_pkg.sv
// Shared constants and helper functions for the enabled N-to-2^N decoder.
// Optional build macro: DECODER_WITH_ENABLER_BYPASS_EN (see decoder_out_reg).
package decoder_pkg;

    // Legal range of the code width N.
    localparam int N_MIN     = 1;
    localparam int N_MAX     = 8;
    localparam int OUT_W_MAX = 1 << N_MAX;

    // Full-width one-hot decode. The enable is checked first so an unknown
    // code while disabled can never reach the result. The code is masked to
    // n bits and the shift is done at the full output width, so no code bit is
    // truncated or sign-extended into the result.
    function automatic logic [OUT_W_MAX-1:0] onehot_decode(
        input logic [N_MAX-1:0] code,
        input logic             enabler,
        input int               n
    );
        logic [N_MAX-1:0]     mask;
        logic [OUT_W_MAX-1:0] result;
        mask   = N_MAX'((1 << n) - 1);
        result = '0;
        if (enabler) begin
            result = OUT_W_MAX'(1) << (code & mask);
        end
        return result;
    endfunction

    // Number of set bits in a vector. The assertions use it for the
    // one-hot-or-zero check.
    function automatic int popcount(input logic [OUT_W_MAX-1:0] v);
        int count;
        count = 0;
        for (int i = 0; i < OUT_W_MAX; i++) begin
            count += int'(v[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/decoder_out_reg.sv
// W-bit output register with a synchronous active-low clear.
// When DECODER_WITH_ENABLER_BYPASS_EN is defined, the register is removed and
// q follows d combinationally. clk and rst_n are then unused.
module decoder_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

`ifdef DECODER_WITH_ENABLER_BYPASS_EN
    // In the zero-latency build the clock and reset are kept only as ports.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    // Pass the decode straight through.
    assign q = d;
`else
    logic [W-1:0] q_q;

    // Capture the decode on every edge. Reset takes priority over the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;
`endif

endmodule

// File: rtl/decoder_with_enabler_n.sv
// Parameterised N-to-2^N decoder with enable and a registered one-hot output.
// The output is driven straight from flops. If DECODER_WITH_ENABLER_BYPASS_EN
// is defined, the output is combinational with zero latency instead.
module decoder_with_enabler_n
    import decoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      code,
    input  logic              enabler,
    output logic [(1<<N)-1:0] o
);

    localparam int W = 1 << N;

    // Refuse to elaborate outside the supported code widths.
    generate
        if (N < N_MIN || N > N_MAX) begin : g_bad_n
            $error("decoder_with_enabler_n: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
        end
    endgenerate

    logic [W-1:0] decode_d;

    // Combinational decode of the current inputs. The register stage follows.
    always_comb begin
        decode_d = W'(onehot_decode(N_MAX'(code), enabler, N));
    end

    decoder_out_reg #(
        .W (W)
    ) u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (decode_d),
        .q     (o)
    );

`ifndef SYNTHESIS
    // The output is never more than one-hot.
    a_onehot0: assert property (@(posedge clk) popcount(OUT_W_MAX'(o)) <= 1)
        else $error("decoder_with_enabler_n: output not one-hot-or-zero");
`ifdef DECODER_WITH_ENABLER_BYPASS_EN
    // In the combinational build, a disabled decoder gives zero at once.
    always_comb begin
        a_disable_zero: assert (enabler !== 1'b0 || o == '0)
            else $error("decoder_with_enabler_n: output set while disabled");
    end
`else
    // A disabled cycle gives an all-zero output after the next edge.
    a_disable_zero: assert property (@(posedge clk) !enabler |=> (o == '0))
        else $error("decoder_with_enabler_n: output set after disabled cycle");
`endif
`endif

endmodule

// File: tb/tb_decoder_with_enabler_n.sv
// Scoreboard bench for decoder_with_enabler_n at N=4, N=1 and N=8.
module tb_decoder_with_enabler_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   code4;
    logic         en4;
    logic [15:0]  o4;
    logic [0:0]   code1;
    logic         en1;
    logic [1:0]   o1;
    logic [7:0]   code8;
    logic         en8;
    logic [255:0] o8;

    int total = 0;
    int bad   = 0;

    logic [15:0]  exp4_q[$];
    logic [1:0]   exp1_q[$];
    logic [255:0] exp8_q[$];

    decoder_with_enabler_n #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .code(code4), .enabler(en4), .o(o4));
    decoder_with_enabler_n #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .code(code1), .enabler(en1), .o(o1));
    decoder_with_enabler_n #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .code(code8), .enabler(en8), .o(o8));

    // Reset affects the output only in the registered build.
    function automatic logic rst_active(input logic r);
`ifdef DECODER_WITH_ENABLER_BYPASS_EN
        return 1'b0;
`else
        return !r;
`endif
    endfunction

    // Drive the N=4 inputs and push the expected output.
    task automatic drive4(input logic r, input logic e, input logic [3:0] c);
        logic [15:0] one;
        @(negedge clk);
        rst_n = r; en4 = e; code4 = c;
        one = 16'd1;
        exp4_q.push_back((rst_active(r) || !e) ? 16'h0000 : (one << c));
    endtask

    // Wait until the driven inputs are visible on the outputs.
    task automatic settle();
`ifdef DECODER_WITH_ENABLER_BYPASS_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive4((i == 2), 1'b1, 4'b0101);
            settle();
            exp = exp4_q.pop_front();
            total++;
            if (o4 !== exp) begin
                bad++;
                $display("FAIL reset[%0d]: o=%h expected %h", i, o4, exp);
            end else $display("reset[%0d]: o=%h ok", i, o4);
        end
    endtask

    task automatic test_sweep_enabled();
        logic [15:0] exp;
        for (int c = 0; c < 16; c++) begin
            drive4(1'b1, 1'b1, 4'(c));
            settle();
            exp = exp4_q.pop_front();
            total++;
            if (o4 !== exp) begin
                bad++;
                $display("FAIL sweep_en code=%0d: o=%h expected %h", c, o4, exp);
            end else $display("sweep_en code=%0d: o=%h ok", c, o4);
            total++;
            if ($countones(o4) != 1) begin
                bad++;
                $display("FAIL onehot code=%0d: ones=%0d expected 1", c, $countones(o4));
            end
        end
    endtask

    task automatic test_sweep_disabled();
        logic [15:0] exp;
        for (int c = 0; c < 16; c++) begin
            drive4(1'b1, 1'b0, 4'(c));
            settle();
            exp = exp4_q.pop_front();
            total++;
            if (o4 !== exp) begin
                bad++;
                $display("FAIL sweep_dis code=%0d: o=%h expected %h", c, o4, exp);
            end else $display("sweep_dis code=%0d: o=%h ok", c, o4);
        end
    endtask

    task automatic test_simultaneous_change();
        logic [15:0] exp;
        drive4(1'b1, 1'b1, 4'hF);
        settle();
        exp = exp4_q.pop_front();
        total++;
        if (o4 !== exp) begin
            bad++;
            $display("FAIL simul_msb: o=%h expected %h", o4, exp);
        end else $display("simul_msb: o=%h ok", o4);
        drive4(1'b1, 1'b0, 4'h3);
        settle();
        exp = exp4_q.pop_front();
        total++;
        if (o4 !== exp) begin
            bad++;
            $display("FAIL simul_off: o=%h expected %h", o4, exp);
        end else $display("simul_off: o=%h ok", o4);
    endtask

    task automatic test_back_to_back_reset();
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive4((i != 1), 1'b1, 4'h7);
            settle();
            exp = exp4_q.pop_front();
            total++;
            if (o4 !== exp) begin
                bad++;
                $display("FAIL reset_pulse[%0d]: o=%h expected %h", i, o4, exp);
            end else $display("reset_pulse[%0d]: o=%h ok", i, o4);
        end
    endtask

    task automatic test_widths();
        logic [1:0]   exp1;
        logic [255:0] exp8;
        logic [255:0] one8;
        one8 = 256'd1;
        // Each pair is (enable, code) for both instances: the maximum code,
        // code 0, then disabled with the maximum code.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst_n = 1'b1;
            en1   = (k != 2);
            en8   = (k != 2);
            code1 = (k == 1) ? 1'b0 : 1'b1;
            code8 = (k == 1) ? 8'd0 : 8'd255;
            exp1_q.push_back(en1 ? (2'b01 << code1) : 2'b00);
            exp8_q.push_back(en8 ? (one8 << code8) : 256'd0);
            settle();
            exp1 = exp1_q.pop_front();
            exp8 = exp8_q.pop_front();
            total++;
            if (o1 !== exp1) begin
                bad++;
                $display("FAIL n1[%0d]: o=%b expected %b", k, o1, exp1);
            end else $display("n1[%0d]: o=%b ok", k, o1);
            total++;
            if (o8 !== exp8) begin
                bad++;
                $display("FAIL n8[%0d]: o[255]=%b ones=%0d expected o[255]=%b ones=%0d",
                         k, o8[255], $countones(o8), exp8[255], $countones(exp8));
            end else $display("n8[%0d]: o[255]=%b o[0]=%b ok", k, o8[255], o8[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en4 = 1'b0; code4 = '0;
        en1 = 1'b0; code1 = '0;
        en8 = 1'b0; code8 = '0;
        test_reset();
        test_sweep_enabled();
        test_sweep_disabled();
        test_simultaneous_change();
        test_back_to_back_reset();
        test_widths();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
